// File: rtl/tiny32_intc_pkg.sv
// Shared definitions for the tiny32 vectored interrupt controller: register
// map, STATUS field layout and the nesting stack entry.
package tiny32_intc_pkg;

    localparam logic [2:0] REG_ENABLE   = 3'd0;
    localparam logic [2:0] REG_MODE     = 3'd1;
    localparam logic [2:0] REG_PENDING  = 3'd2;
    localparam logic [2:0] REG_PRIORITY = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_SWTRIG   = 3'd5;

    localparam int STATUS_ERR_BIT   = 31;
    localparam int STATUS_DEPTH_LSB = 8;
    localparam int STATUS_LEVEL_LSB = 4;
    localparam int STATUS_ID_LSB    = 0;

    // One saved context: the level and active id that were current when a
    // nested interrupt was taken.
    typedef struct packed {
        logic [3:0] level;
        logic [3:0] id;
    } stack_entry_t;

    function automatic logic [31:0] pack_status(input logic       err,
                                                input logic [3:0] depth,
                                                input logic [3:0] level,
                                                input logic [3:0] id);
        logic [31:0] s;
        s = '0;
        s[STATUS_ERR_BIT]            = err;
        s[STATUS_DEPTH_LSB +: 4]     = depth;
        s[STATUS_LEVEL_LSB +: 4]     = level;
        s[STATUS_ID_LSB +: 4]        = id;
        return s;
    endfunction

endpackage

// File: rtl/tiny32_intc_prio_sel.sv
// Candidate filter and arbiter: picks the highest-priority pending, enabled
// channel whose priority beats the current level; ties go to the higher index.
module tiny32_intc_prio_sel
    import tiny32_intc_pkg::*;
#(
    parameter int CHANNELS  = 8,
    parameter int PRIO_BITS = 2
) (
    input  logic [CHANNELS-1:0]           cand_pending,
    input  logic [CHANNELS-1:0]           cand_enable,
    input  logic [CHANNELS*PRIO_BITS-1:0] prio_vec,
    input  logic [3:0]                    cur_level,
    output logic                          sel_valid,
    output logic [3:0]                    sel_channel,
    output logic [PRIO_BITS-1:0]          sel_prio
);

    logic [PRIO_BITS-1:0] p;

    // Ascending scan with >= so a later (higher) channel wins a priority tie
    always_comb begin
        sel_valid   = 1'b0;
        sel_channel = '0;
        sel_prio    = '0;
        p           = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            p = prio_vec[c*PRIO_BITS +: PRIO_BITS];
            if (cand_pending[c] && cand_enable[c] &&
                ((int'(p) + 1) > int'(cur_level))) begin
                if (!sel_valid || (p >= sel_prio)) begin
                    sel_valid   = 1'b1;
                    sel_channel = 4'(c);
                    sel_prio    = p;
                end
            end
        end
    end

endmodule

// File: rtl/tiny32_intc.sv
// tiny32 vectored interrupt controller: synchronised IRQ inputs, edge/level
// pending, programmable priority and nested preemption with a level stack.
module tiny32_intc
    import tiny32_intc_pkg::*;
#(
    parameter int          CHANNELS     = 8,
    parameter int          PRIO_BITS    = 2,
    parameter int          NEST_DEPTH   = 4,
    parameter logic [31:0] VECTOR_BASE  = 32'h0,
    parameter int          VECTOR_SHIFT = 2
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic [CHANNELS-1:0] irq_in,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_addr,
    input  logic [31:0]         cfg_wdata,
    output logic [31:0]         cfg_rdata,
    output logic                int_req,
    output logic [3:0]          int_id,
    output logic [31:0]         int_vector,
    input  logic                int_ack,
    input  logic                int_return,
    output logic                wake
);

    localparam int PW = CHANNELS * PRIO_BITS;

    logic [CHANNELS-1:0]  sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic [CHANNELS-1:0]  enable_q, enable_d, mode_q, mode_d, pend_q, pend_d;
    logic [PW-1:0]        prio_q, prio_d;
    logic                 err_q, err_d;
    logic [3:0]           level_q, level_d, active_q, active_d, depth_q, depth_d;
    stack_entry_t         stack_q [NEST_DEPTH];
    stack_entry_t         stack_d [NEST_DEPTH];
    logic                 int_req_q, int_req_d;
    logic [3:0]           int_id_q, int_id_d;
    logic [PRIO_BITS-1:0] req_prio_q, req_prio_d;
    logic [31:0]          int_vector_q, int_vector_d;
    logic                 wake_q, wake_d;
    logic [31:0]          cfg_rdata_q, cfg_rdata_d;

    logic [CHANNELS-1:0]  rise, w1c, sw_set, ack_clr, sel_pend;
    logic                 ack_ok, ret_ok;
    logic                 sel_valid;
    logic [3:0]           sel_channel;
    logic [PRIO_BITS-1:0] sel_prio;
    logic                 unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    // Register writes, pending bits and the level/stack bookkeeping for ack and return
    always_comb begin
        sync1_d  = irq_in;
        sync2_d  = sync1_q;
        sync3_d  = sync2_q;
        enable_d = enable_q;
        mode_d   = mode_q;
        prio_d   = prio_q;
        err_d    = err_q;
        level_d  = level_q;
        active_d = active_q;
        depth_d  = depth_q;
        stack_d  = stack_q;
        w1c      = '0;
        sw_set   = '0;
        ack_clr  = '0;
        rise     = sync2_q & ~sync3_q;
        // A return in the same cycle wins; the ack is dropped and the core re-sees the request
        ack_ok   = int_ack && int_req_q && !int_return;
        ret_ok   = int_return && (depth_q != 4'd0);

        if (cfg_we) begin
            case (cfg_addr)
                REG_ENABLE:   enable_d = cfg_wdata[CHANNELS-1:0];
                REG_MODE:     mode_d   = cfg_wdata[CHANNELS-1:0];
                REG_PENDING:  w1c      = cfg_wdata[CHANNELS-1:0];
                REG_PRIORITY: prio_d   = cfg_wdata[PW-1:0];
                REG_STATUS:   if (cfg_wdata[STATUS_ERR_BIT]) err_d = 1'b0;
                REG_SWTRIG:   sw_set   = cfg_wdata[CHANNELS-1:0] & mode_q;
                default:      ;
            endcase
        end
        if (int_return && (depth_q == 4'd0)) begin
            err_d = 1'b1;
        end

        for (int c = 0; c < CHANNELS; c++) begin
            ack_clr[c] = ack_ok && (int_id_q == 4'(c + 1));
        end
        // Edge: sets beat clears. Level: mirrors the synchronised line.
        pend_d   = (mode_q & ((pend_q & ~(w1c | ack_clr)) | rise | sw_set)) |
                   (~mode_q & sync2_q);
        // Selection must not re-offer the channel being acknowledged this cycle
        sel_pend = pend_q & ~ack_clr;

        if (ret_ok) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (4'(i) == (depth_q - 4'd1)) begin
                    level_d  = stack_q[i].level;
                    active_d = stack_q[i].id;
                end
            end
            depth_d = depth_q - 4'd1;
        end else if (ack_ok) begin
            for (int i = 0; i < NEST_DEPTH; i++) begin
                if (4'(i) == depth_q) begin
                    stack_d[i].level = level_q;
                    stack_d[i].id    = active_q;
                end
            end
            level_d  = 4'(int'(req_prio_q) + 1);
            active_d = int_id_q;
            depth_d  = depth_q + 4'd1;
        end
    end

    tiny32_intc_prio_sel #(
        .CHANNELS  (CHANNELS),
        .PRIO_BITS (PRIO_BITS)
    ) u_prio_sel (
        .cand_pending (sel_pend),
        .cand_enable  (enable_q),
        .prio_vec     (prio_q),
        .cur_level    (level_d),
        .sel_valid    (sel_valid),
        .sel_channel  (sel_channel),
        .sel_prio     (sel_prio)
    );

    // Request outputs judged against the post-ack/return state, plus wake and read mux
    always_comb begin
        int_req_d    = sel_valid && (depth_d != 4'(NEST_DEPTH));
        int_id_d     = int_req_d ? (sel_channel + 4'd1) : 4'd0;
        req_prio_d   = sel_prio;
        int_vector_d = VECTOR_BASE + (32'(int_id_d) << VECTOR_SHIFT);
        wake_d       = |(pend_q & enable_q);
        cfg_rdata_d  = '0;
        case (cfg_addr)
            REG_ENABLE:   cfg_rdata_d = 32'(enable_q);
            REG_MODE:     cfg_rdata_d = 32'(mode_q);
            REG_PENDING:  cfg_rdata_d = 32'(pend_q);
            REG_PRIORITY: cfg_rdata_d = 32'(prio_q);
            REG_STATUS:   cfg_rdata_d = pack_status(err_q, depth_q, level_q, active_q);
            default:      cfg_rdata_d = '0;
        endcase
    end

    // State registers; reset discards any in-flight handler context
    always_ff @(posedge clk) begin
        if (!nreset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            sync3_q      <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            pend_q       <= '0;
            prio_q       <= '0;
            err_q        <= 1'b0;
            level_q      <= '0;
            active_q     <= '0;
            depth_q      <= '0;
            for (int i = 0; i < NEST_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            req_prio_q   <= '0;
            int_vector_q <= VECTOR_BASE;
            wake_q       <= 1'b0;
            cfg_rdata_q  <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            sync3_q      <= sync3_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            pend_q       <= pend_d;
            prio_q       <= prio_d;
            err_q        <= err_d;
            level_q      <= level_d;
            active_q     <= active_d;
            depth_q      <= depth_d;
            stack_q      <= stack_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            req_prio_q   <= req_prio_d;
            int_vector_q <= int_vector_d;
            wake_q       <= wake_d;
            cfg_rdata_q  <= cfg_rdata_d;
        end
    end

    assign cfg_rdata  = cfg_rdata_q;
    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign int_vector = int_vector_q;
    assign wake       = wake_q;

endmodule

// File: tb/tb_tiny32_intc.sv
// Bench for tiny32_intc: directed steps followed by random traffic, checked
// against a transaction-level model of pending, priority and nesting rules.
module tb_tiny32_intc;
    import tiny32_intc_pkg::*;

    localparam int CH = 8;
    localparam int ND = 2;

    logic        clk;
    logic        nreset;
    logic [7:0]  irq_in;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        int_req;
    logic [3:0]  int_id;
    logic [31:0] int_vector;
    logic        int_ack;
    logic        int_return;
    logic        wake;

    tiny32_intc #(
        .CHANNELS     (CH),
        .PRIO_BITS    (2),
        .NEST_DEPTH   (ND),
        .VECTOR_BASE  (32'h0),
        .VECTOR_SHIFT (2)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .irq_in     (irq_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_return (int_return),
        .wake       (wake)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0]  m_en, m_mode, m_pend_edge, m_irq;
    logic [15:0] m_prio;
    int          m_level, m_active;
    logic        m_err;
    int          m_stk_lvl[$];
    int          m_stk_id[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (5) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_en = '0; m_mode = '0; m_pend_edge = '0; m_irq = '0; m_prio = '0;
        m_level = 0; m_active = 0; m_err = 1'b0;
        m_stk_lvl.delete();
        m_stk_id.delete();
    endtask

    function automatic logic [7:0] pend_eff();
        return (m_pend_edge & m_mode) | (m_irq & ~m_mode);
    endfunction

    function automatic logic [31:0] exp_status();
        return {m_err, 19'd0, 4'(m_stk_lvl.size()), 4'(m_level), 4'(m_active)};
    endfunction

    task automatic model_sel(output logic v, output logic [3:0] id);
        logic [7:0] pe;
        int best, p;
        pe = pend_eff();
        v = 1'b0; id = '0; best = -1;
        for (int c = 0; c < CH; c++) begin
            p = int'(m_prio[2*c +: 2]);
            if (pe[c] && m_en[c] && (p + 1 > m_level) && (p >= best)) begin
                v = 1'b1; id = 4'(c + 1); best = p;
            end
        end
        if (m_stk_lvl.size() >= ND) begin
            v = 1'b0; id = '0;
        end
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        irq_in = '0;
        repeat (2) tick();
        nreset = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0; cfg_wdata = '0;
        case (a)
            REG_ENABLE:   m_en = d[7:0];
            REG_MODE:     begin m_mode = d[7:0]; m_pend_edge = m_pend_edge & m_mode; end
            REG_PENDING:  m_pend_edge = m_pend_edge & ~d[7:0];
            REG_PRIORITY: m_prio = d[15:0];
            REG_STATUS:   if (d[31]) m_err = 1'b0;
            REG_SWTRIG:   m_pend_edge = m_pend_edge | (d[7:0] & m_mode);
            default:      ;
        endcase
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_addr = a;
        tick();
        d = cfg_rdata;
    endtask

    // Edge-mode bits are pulsed; level-mode bits are left at the new value
    task automatic drive_irq(input logic [7:0] v);
        irq_in = v;
        m_pend_edge = m_pend_edge | (v & m_mode & ~m_irq);
        repeat (3) tick();
        irq_in = v & ~m_mode;
        m_irq = v & ~m_mode;
    endtask

    task automatic do_ack();
        logic v;
        logic [3:0] id;
        int ch;
        model_sel(v, id);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        if (v) begin
            ch = int'(id) - 1;
            m_stk_lvl.push_back(m_level);
            m_stk_id.push_back(m_active);
            m_level = int'(m_prio[2*ch +: 2]) + 1;
            m_active = int'(id);
            if (m_mode[ch]) m_pend_edge[ch] = 1'b0;
        end
    endtask

    task automatic model_return();
        if (m_stk_lvl.size() == 0) begin
            m_err = 1'b1;
        end else begin
            m_level = m_stk_lvl.pop_back();
            m_active = m_stk_id.pop_back();
        end
    endtask

    task automatic do_ret();
        int_return = 1'b1;
        tick();
        int_return = 1'b0;
        model_return();
    endtask

    task automatic do_ack_ret();
        int_ack = 1'b1; int_return = 1'b1;
        tick();
        int_ack = 1'b0; int_return = 1'b0;
        model_return();
    endtask

    task automatic check_all(input string tag);
        logic v;
        logic [3:0] id;
        logic [31:0] rd;
        model_sel(v, id);
        check({tag, "_req"}, 32'(int_req), 32'(v));
        check({tag, "_id"}, 32'(int_id), 32'(id));
        check({tag, "_vec"}, int_vector, 32'(id) << 2);
        check({tag, "_wake"}, 32'(wake), 32'(|(pend_eff() & m_en)));
        cfg_read(REG_STATUS, rd);
        check({tag, "_status"}, rd, exp_status());
        cfg_read(REG_PENDING, rd);
        check({tag, "_pending"}, rd, 32'(pend_eff()));
    endtask

    initial begin
        logic [31:0] rd;
        logic v;
        logic [3:0] id;
        int op;

        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        int_ack = 1'b0; int_return = 1'b0; irq_in = '0; nreset = 1'b0;
        do_reset();

        // Reset state
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'h0);
        end
        check("reset_req", 32'(int_req), 32'h0);
        check("reset_id", 32'(int_id), 32'h0);
        check("reset_vec", int_vector, 32'h0);
        check("reset_wake", 32'(wake), 32'h0);

        // Single edge channel: latency, vector, ack
        cfg_write(REG_ENABLE, 32'h01);
        cfg_write(REG_MODE, 32'h01);
        settle();
        irq_in = 8'h01;
        tick();
        tick();
        tick();
        check("lat_k2_req", 32'(int_req), 32'h0);
        tick();
        check("lat_k3_req", 32'(int_req), 32'h1);
        check("lat_k3_id", 32'(int_id), 32'h1);
        check("lat_k3_vec", int_vector, 32'h4);
        irq_in = 8'h00;
        m_pend_edge[0] = 1'b1;
        settle();
        check_all("single_pend");
        do_ack();
        settle();
        cfg_read(REG_STATUS, rd);
        check("single_ack_status", rd, 32'h111);
        check_all("single_ack");
        do_ret();
        settle();
        check_all("single_ret");

        // Equal priority tie: higher index first, lower waits for return
        cfg_write(REG_ENABLE, 32'h24);
        cfg_write(REG_MODE, 32'h24);
        drive_irq(8'h24);
        settle();
        check("tie_first_id", 32'(int_id), 32'h6);
        check_all("tie_first");
        do_ack();
        settle();
        check("tie_blocked_req", 32'(int_req), 32'h0);
        check_all("tie_blocked");
        do_ret();
        settle();
        check("tie_second_id", 32'(int_id), 32'h3);
        do_ack();
        do_ret();
        settle();
        check_all("tie_done");

        // Nesting up to the depth limit
        cfg_write(REG_PRIORITY, 32'h39);
        cfg_write(REG_ENABLE, 32'h07);
        cfg_write(REG_MODE, 32'h07);
        drive_irq(8'h01);
        settle();
        do_ack();
        drive_irq(8'h02);
        settle();
        check("nest_preempt_id", 32'(int_id), 32'h2);
        do_ack();
        settle();
        cfg_read(REG_STATUS, rd);
        check("nest_depth2_status", rd, 32'h232);
        drive_irq(8'h04);
        settle();
        check("nest_full_req", 32'(int_req), 32'h0);
        check_all("nest_full");
        do_ret();
        settle();
        check("nest_unblock_id", 32'(int_id), 32'h3);
        cfg_write(REG_PENDING, 32'h04);
        settle();
        do_ret();
        settle();
        cfg_read(REG_STATUS, rd);
        check("nest_unwound_status", rd, 32'h0);
        check_all("nest_unwound");

        // Level-mode channel
        cfg_write(REG_MODE, 32'h00);
        cfg_write(REG_ENABLE, 32'h08);
        cfg_write(REG_PRIORITY, 32'h00);
        drive_irq(8'h08);
        settle();
        check("level_id", 32'(int_id), 32'h4);
        do_ack();
        settle();
        check("level_acked_req", 32'(int_req), 32'h0);
        cfg_write(REG_PENDING, 32'h08);
        settle();
        cfg_read(REG_PENDING, rd);
        check("level_w1c_pending", rd, 32'h08);
        do_ret();
        settle();
        check("level_rereq_id", 32'(int_id), 32'h4);
        drive_irq(8'h00);
        settle();
        check_all("level_drop");

        // Sticky error, clear, and simultaneous ack+return
        do_ret();
        settle();
        cfg_read(REG_STATUS, rd);
        check("err_set_status", rd, 32'h80000000);
        cfg_write(REG_STATUS, 32'h80000000);
        cfg_read(REG_STATUS, rd);
        check("err_clr_status", rd, 32'h0);
        cfg_write(REG_MODE, 32'h03);
        cfg_write(REG_ENABLE, 32'h03);
        cfg_write(REG_PRIORITY, 32'h04);
        drive_irq(8'h01);
        settle();
        do_ack();
        drive_irq(8'h02);
        settle();
        check("ackret_pre_id", 32'(int_id), 32'h2);
        do_ack_ret();
        settle();
        cfg_read(REG_STATUS, rd);
        check("ackret_status", rd, 32'h0);
        check("ackret_id", 32'(int_id), 32'h2);
        do_ack();
        do_ret();
        settle();
        check_all("ackret_done");

        // Random traffic against the model
        cfg_write(REG_MODE, 32'h0F);
        cfg_write(REG_ENABLE, 32'($urandom_range(0, 255)));
        cfg_write(REG_PRIORITY, 32'($urandom_range(0, 65535)));
        for (int it = 0; it < 60; it++) begin
            op = int'($urandom_range(0, 7));
            case (op)
                0, 1: drive_irq(8'($urandom_range(0, 255)));
                2: begin
                    model_sel(v, id);
                    if (v) do_ack();
                end
                3: do_ret();
                4: cfg_write(REG_ENABLE, 32'($urandom_range(0, 255)));
                5: cfg_write(REG_PRIORITY, 32'($urandom_range(0, 65535)));
                6: cfg_write(($urandom_range(0, 1) != 0) ? REG_SWTRIG : REG_PENDING,
                             32'($urandom_range(0, 255)));
                default: cfg_write(REG_STATUS, 32'h80000000);
            endcase
            settle();
            check_all($sformatf("rnd%0d", it));
        end

        // Reset while a handler is active
        drive_irq(8'h00);
        settle();
        while (m_stk_lvl.size() > 0) do_ret();
        cfg_write(REG_ENABLE, 32'h01);
        cfg_write(REG_SWTRIG, 32'h01);
        settle();
        do_ack();
        settle();
        check_all("midreset_pre");
        do_reset();
        cfg_read(REG_STATUS, rd);
        check("midreset_status", rd, 32'h0);
        cfg_read(REG_ENABLE, rd);
        check("midreset_enable", rd, 32'h0);
        check("midreset_req", 32'(int_req), 32'h0);
        check("midreset_vec", int_vector, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
